// File: rtl/m_pkg.sv
// rtl/m_pkg.sv - shared types, decode constants and op-class helpers for the M-extension unit
package m_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } m_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } m_state_e;

    localparam logic [6:0] M_OPCODE = 7'b0110011;
    localparam logic [6:0] M_FUNCT7 = 7'b0000001;

    function automatic logic op_is_div(input m_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic op_is_rem(input m_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    // MUL keeps only the low half, which is the same for signed and unsigned operands
    function automatic logic op_rs1_signed(input m_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_rs2_signed(input m_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/m_div_step.sv
// rtl/m_div_step.sv - one combinational restoring-division step
module m_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   partial,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_nx,
    output logic            q_bit
);
    // When the subtract succeeds the true difference is below the divisor, so XLEN bits suffice
    assign q_bit  = partial >= {1'b0, divisor};
    assign rem_nx = q_bit ? (partial[XLEN-1:0] - divisor) : partial[XLEN-1:0];
endmodule

// File: rtl/m_muldiv_seq.sv
// rtl/m_muldiv_seq.sv - sequential RV M-extension unit on PCPI; DIV_REM_FUSE_EN enables the division result cache
module m_muldiv_seq
    import m_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            wr,
    output logic [XLEN-1:0] rd,
    output logic            busy,
    output logic            ready
);
    localparam int CW      = $clog2(XLEN);
    localparam int MUL_CYC = XLEN / MUL_STEP;

    m_state_e          state, state_nx;
    m_op_e             op, dec_op;
    logic              is_m, dec_div, sgn_a, sgn_b, accept, fuse_hit;
    logic              neg_q, neg_r, step_q;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   a_mag, b_mag, divisor, shreg, rem, result;
    logic [XLEN-1:0]   step_rem, q_fix, r_fix, fix_res, fuse_res;
    logic [2*XLEN-1:0] acc, mcand, pp, prod;
    logic              unused_instr;

    assign unused_instr = ^{instruction[24:15], instruction[11:7]};

    assign is_m    = (instruction[6:0] == M_OPCODE) && (instruction[31:25] == M_FUNCT7);
    assign dec_op  = m_op_e'(instruction[14:12]);
    assign dec_div = op_is_div(dec_op);
    assign sgn_a   = op_rs1_signed(dec_op) && rs1[XLEN-1];
    assign sgn_b   = op_rs2_signed(dec_op) && rs2[XLEN-1];
    assign a_mag   = sgn_a ? -rs1 : rs1;
    assign b_mag   = sgn_b ? -rs2 : rs2;
    assign accept  = (state == S_IDLE) && valid && is_m;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = fuse_hit ? S_DONE : (dec_div ? S_DIV : S_MUL);
            S_MUL: begin
                if (!valid)                          state_nx = S_IDLE;
                else if (cnt == CW'(MUL_CYC - 1))    state_nx = S_FIX;
            end
            S_DIV: begin
                if (!valid)                          state_nx = S_IDLE;
                else if (cnt == CW'(XLEN - 1))       state_nx = S_FIX;
            end
            S_FIX:  state_nx = valid ? S_DONE : S_IDLE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy  = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
    assign ready = (state == S_DONE);
    assign wr    = ready;
    assign rd    = ready ? result : '0;

    m_div_step #(.XLEN(XLEN)) u_div_step (
        .partial ({rem, shreg[XLEN-1]}),
        .divisor (divisor),
        .rem_nx  (step_rem),
        .q_bit   (step_q)
    );

    // shreg holds the multiplier during MUL and the dividend/quotient during DIV
    assign pp    = mcand * {{(2*XLEN-MUL_STEP){1'b0}}, shreg[MUL_STEP-1:0]};
    assign prod  = neg_q ? -acc : acc;
    assign q_fix = (neg_q && divisor != '0) ? -shreg : shreg;
    assign r_fix = neg_r ? -rem : rem;

    always_comb begin
        fix_res = q_fix;
        case (op)
            OP_MUL:                       fix_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
            OP_REM, OP_REMU:              fix_res = r_fix;
            default:                      fix_res = q_fix;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op      <= OP_MUL;
            cnt     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            divisor <= '0;
            acc     <= '0;
            mcand   <= '0;
            shreg   <= '0;
            rem     <= '0;
            result  <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    op      <= dec_op;
                    cnt     <= '0;
                    neg_q   <= sgn_a ^ sgn_b;
                    neg_r   <= sgn_a;
                    divisor <= b_mag;
                    acc     <= '0;
                    mcand   <= {{XLEN{1'b0}}, a_mag};
                    shreg   <= dec_div ? a_mag : b_mag;
                    rem     <= '0;
                    if (fuse_hit) result <= fuse_res;
                end
                S_MUL: begin
                    acc   <= acc + pp;
                    mcand <= mcand << MUL_STEP;
                    shreg <= shreg >> MUL_STEP;
                    cnt   <= cnt + 1'b1;
                end
                S_DIV: begin
                    rem   <= step_rem;
                    shreg <= {shreg[XLEN-2:0], step_q};
                    cnt   <= cnt + 1'b1;
                end
                S_FIX:   result <= fix_res;
                default: ;
            endcase
        end
    end

`ifdef DIV_REM_FUSE_EN
    logic            c_valid, c_signed, l_signed;
    logic [XLEN-1:0] c_rs1, c_rs2, c_q, c_r, l_rs1, l_rs2;

    assign fuse_hit = c_valid && dec_div && (rs1 == c_rs1) && (rs2 == c_rs2)
                      && (op_rs1_signed(dec_op) == c_signed);
    assign fuse_res = op_is_rem(dec_op) ? c_r : c_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_valid  <= 1'b0;
            c_signed <= 1'b0;
            l_signed <= 1'b0;
            c_rs1    <= '0;
            c_rs2    <= '0;
            c_q      <= '0;
            c_r      <= '0;
            l_rs1    <= '0;
            l_rs2    <= '0;
        end else begin
            if (accept) begin
                l_rs1    <= rs1;
                l_rs2    <= rs2;
                l_signed <= op_rs1_signed(dec_op);
            end
            // both halves are kept so the partner op can complete without iterating
            if ((state == S_DIV || state == S_FIX) && op_is_div(op)) begin
                if (!valid) begin
                    c_valid <= 1'b0;
                end else if (state == S_FIX) begin
                    c_valid  <= 1'b1;
                    c_rs1    <= l_rs1;
                    c_rs2    <= l_rs2;
                    c_signed <= l_signed;
                    c_q      <= q_fix;
                    c_r      <= r_fix;
                end
            end
        end
    end
`else
    assign fuse_hit = 1'b0;
    assign fuse_res = '0;
`endif

endmodule

// File: tb/tb_m_muldiv_seq.sv
// tb/tb_m_muldiv_seq.sv - bench for m_muldiv_seq (XLEN 32/4 and 64/8); honours DIV_REM_FUSE_EN
module tb_m_muldiv_seq;

    logic        clk = 1'b0, reset = 1'b1, valid = 1'b0;
    logic [31:0] instruction = '0, rs1 = '0, rs2 = '0;
    logic        wr, busy, ready;
    logic [31:0] rd;

    logic        valid64 = 1'b0;
    logic [31:0] instr64 = '0;
    logic [63:0] a64 = '0, b64 = '0;
    logic        wr64, busy64, ready64;
    logic [63:0] rd64;

    int          cyc = 0, acc_cyc = 0, busy_end = 0, exp_due = -1;
    logic [63:0] exp_res = '0;
    logic [2:0]  cur_f3 = '0;
    int          n_chk = 0, n_pass = 0;
    logic        mc_valid = 1'b0, mc_signed = 1'b0;
    logic [31:0] mc_a = '0, mc_b = '0;

    m_muldiv_seq #(.XLEN(32), .MUL_STEP(4)) dut (
        .clk(clk), .reset(reset), .valid(valid), .instruction(instruction),
        .rs1(rs1), .rs2(rs2), .wr(wr), .rd(rd), .busy(busy), .ready(ready)
    );

    m_muldiv_seq #(.XLEN(64), .MUL_STEP(8)) dut64 (
        .clk(clk), .reset(reset), .valid(valid64), .instruction(instr64),
        .rs1(a64), .rs2(b64), .wr(wr64), .rd(rd64), .busy(busy64), .ready(ready64)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        else n_pass++;
    endtask

    function automatic logic [31:0] enc(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic signed [129:0] ext(input logic [63:0] v, input int xl, input logic s);
        logic signed [129:0] r;
        if (xl == 32) r = s ? {{98{v[31]}}, v[31:0]} : {98'b0, v[31:0]};
        else          r = s ? {{66{v[63]}}, v}       : {66'b0, v};
        return r;
    endfunction

    // Reference: exact wide integer arithmetic, truncated to xl bits
    function automatic logic [63:0] model(input logic [2:0] f3, input logic [63:0] a,
                                          input logic [63:0] b, input int xl);
        logic signed [129:0] x, y, p;
        logic [63:0]         mask;
        logic                s1, s2;
        mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        s1 = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
        s2 = f3 inside {3'b000, 3'b001, 3'b100, 3'b110};
        x = ext(a, xl, s1);
        y = ext(b, xl, s2);
        if (f3 == 3'b000) begin
            p = x * y;
            return p[63:0] & mask;
        end else if (!f3[2]) begin
            p = (x * y) >>> xl;
            return p[63:0] & mask;
        end else if ((b & mask) == 64'd0) begin
            return f3[1] ? (a & mask) : mask;
        end else begin
            p = f3[1] ? (x % y) : (x / y);
            return p[63:0] & mask;
        end
    endfunction

    function automatic int lat_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return 32 / 4 + 2;
`ifdef DIV_REM_FUSE_EN
        if (mc_valid && a == mc_a && b == mc_b && mc_signed == !f3[0]) return 1;
`endif
        return 32 + 2;
    endfunction

    always @(negedge clk) begin : cmp
        logic er, eb;
        er = !reset && exp_due >= 0 && cyc == exp_due;
        eb = !reset && cyc > acc_cyc && cyc < busy_end;
        chk("ready", 64'(ready), 64'(er));
        chk("wr", 64'(wr), 64'(er));
        chk("busy", 64'(busy), 64'(eb));
        chk("rd", 64'(rd), er ? exp_res : 64'd0);
    end

    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        instruction = enc(f3);
        rs1 = a;
        rs2 = b;
        valid = 1'b1;
        cur_f3 = f3;
        exp_res = model(f3, {32'd0, a}, {32'd0, b}, 32);
        acc_cyc = cyc;
        exp_due = cyc + lat_of(f3, a, b);
        busy_end = exp_due;
    endtask

    task automatic finish_op(output logic [31:0] got);
        while (cyc != exp_due) @(negedge clk);
        got = rd;
        @(posedge clk); #1;
        valid = 1'b0;
        exp_due = -1;
        if (cur_f3[2]) begin
            mc_valid = 1'b1;
            mc_a = rs1;
            mc_b = rs2;
            mc_signed = !cur_f3[0];
        end
    endtask

    task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] got);
        start_op(f3, a, b);
        finish_op(got);
    endtask

    task automatic run64(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] got);
        logic [63:0] e;
        @(posedge clk); #1;
        instr64 = enc(f3);
        a64 = a;
        b64 = b;
        valid64 = 1'b1;
        e = model(f3, a, b, 64);
        for (int i = 0; i <= 64 / 8 + 2; i++) begin
            @(negedge clk);
            chk("ready64", 64'(ready64), 64'(i == 64 / 8 + 2));
        end
        got = rd64;
        chk("rd64_model", rd64, e);
        @(posedge clk); #1;
        valid64 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        logic [31:0] g;
        logic [63:0] g64;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        run(3'b000, 32'd7, 32'hFFFF_FFFD, g);        chk("mul_lit", 64'(g), 64'hFFFF_FFEB);
        run(3'b001, 32'h8000_0000, 32'h8000_0000, g); chk("mulh_lit", 64'(g), 64'h4000_0000);
        run(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, g); chk("mulhsu_lit", 64'(g), 64'hFFFF_FFFF);
        run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, g); chk("mulhu_lit", 64'(g), 64'hFFFF_FFFE);
        run(3'b100, 32'hFFFF_FFF9, 32'd2, g);         chk("div_lit", 64'(g), 64'hFFFF_FFFD);
        run(3'b110, 32'hFFFF_FFF9, 32'd2, g);         chk("rem_lit", 64'(g), 64'hFFFF_FFFF);
        run(3'b101, 32'd5, 32'd0, g);                 chk("divu_by0", 64'(g), 64'hFFFF_FFFF);
        run(3'b111, 32'd5, 32'd0, g);                 chk("remu_by0", 64'(g), 64'd5);
        run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, g); chk("div_ovf", 64'(g), 64'h8000_0000);
        run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, g); chk("rem_ovf", 64'(g), 64'd0);
        run(3'b110, 32'hFFFF_FFF9, 32'd0, g);         chk("rem_by0_signed", 64'(g), 64'hFFFF_FFF9);

        // abort a division at cycle 5
        start_op(3'b100, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        valid = 1'b0;
        exp_due = -1;
        busy_end = cyc + 1;
        mc_valid = 1'b0;
        run(3'b011, 32'd3, 32'd3, g);                 chk("mulhu_after_abort", 64'(g), 64'd0);

        // reset in the middle of a multiply
        start_op(3'b000, 32'h1234, 32'h5678);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_due = -1;
        busy_end = 0;
        mc_valid = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_ready", 64'(ready), 64'd0);
        chk("rst_mid_rd", 64'(rd), 64'd0);
        @(posedge clk); #1 valid = 1'b0;
        @(posedge clk); #1 reset = 1'b0;

        // non-M instruction is ignored
        @(posedge clk); #1;
        instruction = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
        valid = 1'b1;
        repeat (20) @(posedge clk);
        #1 valid = 1'b0;

        run(3'b100, 32'd100, 32'd7, g);               chk("div_100_7", 64'(g), 64'd14);
        run(3'b110, 32'd100, 32'd7, g);               chk("rem_100_7", 64'(g), 64'd2);
        run(3'b110, 32'd100, 32'd8, g);               chk("rem_100_8", 64'(g), 64'd4);

        run64(3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, g64);
        chk("mul64_lit", g64, 64'hFFFF_FFFF_FFFF_FFEB);
        run64(3'b001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, g64);
        chk("mulh64_lit", g64, 64'h4000_0000_0000_0000);
        run64(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, g64);
        chk("mulhsu64_lit", g64, 64'hFFFF_FFFF_FFFF_FFFF);
        run64(3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, g64);
        chk("mulhu64_lit", g64, 64'hFFFF_FFFF_FFFF_FFFE);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
